// File: rtl/lamp_pkg.sv
// lamp_pkg: shared lamp colours, phase/state encodings, fault codes and next-colour helper
// Imported by lamp_decode, lamp_sequence_monitor and the benches.
package lamp_pkg;
  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;
  typedef enum logic [1:0] {PH_NONE, PH_GREEN, PH_YELLOW, PH_RED} phase_t;
  typedef enum logic [1:0] {SYNC, RUN, FAULT} state_t;
  localparam logic [2:0] FC_NONE    = 3'd0;
  localparam logic [2:0] FC_ILLEGAL = 3'd1;
  localparam logic [2:0] FC_ORDER   = 3'd2;
  localparam logic [2:0] FC_SHORT   = 3'd3;
  localparam logic [2:0] FC_TIMEOUT = 3'd4;
  function automatic phase_t next_colour(input phase_t p);
    return p == PH_GREEN ? PH_YELLOW : p == PH_YELLOW ? PH_RED : p == PH_RED ? PH_GREEN : PH_NONE;
  endfunction
endpackage

// File: rtl/lamp_sequence_monitor_if.sv
// lamp_sequence_monitor_if: lamp bus plus monitor status outputs
// master: drives light/clear, reads status; slave: the monitor itself.
// light [0:2] (bit0=R, bit1=G, bit2=Y), clear, phase, in_sync, fault, fault_code, dwell, cycles.
interface lamp_sequence_monitor_if #(parameter int CNT_W = 8);
  logic [0:2]       light;
  logic             clear;
  logic [1:0]       phase;
  logic             in_sync;
  logic             fault;
  logic [2:0]       fault_code;
  logic [CNT_W-1:0] dwell;
  logic [CNT_W-1:0] cycles;
  modport master (output light, clear, input phase, in_sync, fault, fault_code, dwell, cycles);
  modport slave  (input light, clear, output phase, in_sync, fault, fault_code, dwell, cycles);
endinterface

// File: rtl/lamp_decode.sv
// lamp_decode: combinational map of the lamp bus to a phase and a one-hot flag
// i_light: observed lamp bus; o_phase: decoded colour (PH_NONE if not a colour); o_onehot: exactly one lamp lit.
module lamp_decode
  import lamp_pkg::*;
(
  input  logic [0:2] i_light,
  output phase_t     o_phase,
  output logic       o_onehot
);
  assign o_onehot = $onehot(i_light);
  assign o_phase  = i_light == GREEN ? PH_GREEN : i_light == YELLOW ? PH_YELLOW : i_light == RED ? PH_RED : PH_NONE;
endmodule

// File: rtl/lamp_sequence_monitor.sv
// lamp_sequence_monitor: checks GREEN->YELLOW->RED order and dwell of the lamp bus, latching the first fault
// clock: rising-edge clock; reset_n: async active-low reset; bus: slave modport (light/clear in, status out).
// Optional LAMP_MON_AUTORECOVER_EN: a GREEN sample while in FAULT re-enters RUN (fault_code stays sticky).
module lamp_sequence_monitor
  import lamp_pkg::*;
#(
  parameter int CNT_W     = 8,
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 16
)(
  input  logic clock,
  input  logic reset_n,
  lamp_sequence_monitor_if.slave bus
);
  localparam logic [CNT_W-1:0] MIN_D = CNT_W'(MIN_DWELL);
  localparam logic [CNT_W-1:0] MAX_D = CNT_W'(MAX_DWELL);
  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  state_t           r_state;
  phase_t           r_phase;
  logic             r_in_sync;
  logic             r_fault;
  logic [2:0]       r_code;
  logic [CNT_W-1:0] r_dwell;
  logic [CNT_W-1:0] r_cycles;
  phase_t           w_ph;
  phase_t           w_nxt;
  logic             w_onehot;
  logic [2:0]       w_cause;
  lamp_decode u_decode (.i_light(bus.light), .o_phase(w_ph), .o_onehot(w_onehot));
  assign w_nxt = next_colour(r_phase);
  // Fault cause for a RUN-state sample, in priority order; FC_NONE means advance or hold.
  always_comb begin
    w_cause = !w_onehot ? FC_ILLEGAL :
              (w_ph != r_phase && w_ph != w_nxt) ? FC_ORDER :
              (w_ph == w_nxt && r_dwell < MIN_D) ? FC_SHORT :
              (w_ph == r_phase && r_dwell == MAX_D) ? FC_TIMEOUT : FC_NONE;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= SYNC;
      r_phase   <= PH_NONE;
      r_in_sync <= 1'b0;
      r_fault   <= 1'b0;
      r_code    <= FC_NONE;
      r_dwell   <= '0;
      r_cycles  <= '0;
    end else if (bus.clear) begin
      r_state   <= SYNC;
      r_phase   <= PH_NONE;
      r_in_sync <= 1'b0;
      r_fault   <= 1'b0;
      r_code    <= FC_NONE;
      r_dwell   <= '0;
      r_cycles  <= '0;
    end else begin
      case (r_state)
        SYNC: if (w_ph == PH_GREEN) begin
          r_state   <= RUN;
          r_phase   <= PH_GREEN;
          r_dwell   <= ONE;
          r_in_sync <= 1'b1;
        end
        RUN: if (w_cause != FC_NONE) begin
          r_state   <= FAULT;
          r_fault   <= 1'b1;
          r_in_sync <= 1'b0;
          // Only the first cause since the last clear is kept.
          r_code    <= r_code == FC_NONE ? w_cause : r_code;
        end else if (w_ph == w_nxt) begin
          r_phase  <= w_nxt;
          r_dwell  <= ONE;
          r_cycles <= w_nxt == PH_GREEN ? r_cycles + ONE : r_cycles;
        end else begin
          r_dwell <= r_dwell + ONE;
        end
`ifdef LAMP_MON_AUTORECOVER_EN
        FAULT: if (w_ph == PH_GREEN) begin
          r_state   <= RUN;
          r_phase   <= PH_GREEN;
          r_dwell   <= ONE;
          r_in_sync <= 1'b1;
          r_fault   <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end
  assign bus.phase      = r_phase;
  assign bus.in_sync    = r_in_sync;
  assign bus.fault      = r_fault;
  assign bus.fault_code = r_code;
  assign bus.dwell      = r_dwell;
  assign bus.cycles     = r_cycles;
endmodule

// File: tb/tb_lamp_sequence_monitor.sv
// tb_lamp_sequence_monitor: table-driven check of two monitor configurations plus an async reset sequence
module tb_lamp_sequence_monitor;
  import lamp_pkg::*;
  typedef struct {
    logic       b;
    logic [0:2] light;
    logic       clr;
    logic [1:0] ph;
    logic       sync;
    logic       flt;
    logic [2:0] code;
    logic [7:0] dw;
    logic [7:0] cyc;
  } vec_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int errors = 0;
  int checks = 0;
  vec_t q[$];
  always #5 clock = ~clock;
  lamp_sequence_monitor_if #(.CNT_W(8)) bus_a();
  lamp_sequence_monitor_if #(.CNT_W(2)) bus_b();
  lamp_sequence_monitor #(.CNT_W(8), .MIN_DWELL(2), .MAX_DWELL(4)) dut_a (.clock(clock), .reset_n(reset_n), .bus(bus_a));
  lamp_sequence_monitor #(.CNT_W(2), .MIN_DWELL(1), .MAX_DWELL(3)) dut_b (.clock(clock), .reset_n(reset_n), .bus(bus_b));
  function automatic logic [22:0] obs(input logic b);
    return b ? {bus_b.phase, bus_b.in_sync, bus_b.fault, bus_b.fault_code, 6'd0, bus_b.dwell, 6'd0, bus_b.cycles}
             : {bus_a.phase, bus_a.in_sync, bus_a.fault, bus_a.fault_code, bus_a.dwell, bus_a.cycles};
  endfunction
  task automatic chk(input string name, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got ph=%0d sync=%0d flt=%0d code=%0d dw=%0d cyc=%0d, expected ph=%0d sync=%0d flt=%0d code=%0d dw=%0d cyc=%0d",
               name, act[22:21], act[20], act[19], act[18:16], act[15:8], act[7:0],
               exp[22:21], exp[20], exp[19], exp[18:16], exp[15:8], exp[7:0]);
    end
  endtask
  function automatic void add(input logic b, input logic [0:2] l, input logic c,
                              input int ph, input int sy, input int fl, input int cd, input int dw, input int cy);
    q.push_back('{b, l, c, 2'(ph), 1'(sy), 1'(fl), 3'(cd), 8'(dw), 8'(cy)});
  endfunction
  task automatic run(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      if (q[i].b) begin
        bus_b.light = q[i].light;
        bus_b.clear = q[i].clr;
      end else begin
        bus_a.light = q[i].light;
        bus_a.clear = q[i].clr;
      end
      @(posedge clock);
      #1;
      chk($sformatf("vec%0d", i), obs(q[i].b), {q[i].ph, q[i].sync, q[i].flt, q[i].code, q[i].dw, q[i].cyc});
    end
  endtask
  initial begin
    int na;
    // Config A (MIN_DWELL=2, MAX_DWELL=4): three full rounds then GREEN.
    for (int r = 0; r < 3; r++) begin
      add(0, GREEN, 0, 1, 1, 0, 0, 1, r);
      add(0, GREEN, 0, 1, 1, 0, 0, 2, r);
      add(0, YELLOW, 0, 2, 1, 0, 0, 1, r);
      add(0, YELLOW, 0, 2, 1, 0, 0, 2, r);
      add(0, RED, 0, 3, 1, 0, 0, 1, r);
      add(0, RED, 0, 3, 1, 0, 0, 2, r);
    end
    add(0, GREEN, 0, 1, 1, 0, 0, 1, 3);
    add(0, GREEN, 0, 1, 1, 0, 0, 2, 3);
    add(0, 3'b011, 0, 1, 0, 1, 1, 2, 3);
    add(0, 3'b000, 0, 1, 0, 1, 1, 2, 3);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    add(0, RED, 0, 0, 0, 0, 0, 0, 0);
    add(0, GREEN, 0, 1, 1, 0, 0, 1, 0);
    add(0, GREEN, 0, 1, 1, 0, 0, 2, 0);
    add(0, RED, 0, 1, 0, 1, 2, 2, 0);
`ifdef LAMP_MON_AUTORECOVER_EN
    add(0, GREEN, 0, 1, 1, 0, 2, 1, 0);
`else
    add(0, GREEN, 0, 1, 0, 1, 2, 2, 0);
`endif
    add(0, GREEN, 1, 0, 0, 0, 0, 0, 0);
    add(0, GREEN, 0, 1, 1, 0, 0, 1, 0);
    add(0, YELLOW, 0, 1, 0, 1, 3, 1, 0);
    add(0, 3'b000, 1, 0, 0, 0, 0, 0, 0);
    for (int d = 1; d <= 4; d++) add(0, GREEN, 0, 1, 1, 0, 0, d, 0);
    add(0, GREEN, 0, 1, 0, 1, 4, 4, 0);
`ifdef LAMP_MON_AUTORECOVER_EN
    add(0, GREEN, 0, 1, 1, 0, 4, 1, 0);
`else
    add(0, GREEN, 0, 1, 0, 1, 4, 4, 0);
`endif
    na = q.size();
    // Config B (CNT_W=2, MIN_DWELL=1): five 1-cycle rounds, cycles wraps 3->0->1.
    for (int r = 0; r < 5; r++) begin
      add(1, GREEN, 0, 1, 1, 0, 0, 1, r % 4);
      add(1, YELLOW, 0, 2, 1, 0, 0, 1, r % 4);
      add(1, RED, 0, 3, 1, 0, 0, 1, r % 4);
    end
    add(1, GREEN, 0, 1, 1, 0, 0, 1, 1);
    add(1, 3'b111, 1, 0, 0, 0, 0, 0, 0);
    add(1, YELLOW, 0, 0, 0, 0, 0, 0, 0);
    add(1, GREEN, 0, 1, 1, 0, 0, 1, 0);
    bus_a.light = 3'b000;
    bus_a.clear = 1'b0;
    bus_b.light = 3'b000;
    bus_b.clear = 1'b0;
    #12;
    chk("reset_a", obs(0), 23'd0);
    chk("reset_b", obs(1), 23'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run(0, na);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset", obs(0), 23'd0);
    @(posedge clock);
    #1;
    bus_a.light = 3'b000;
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    chk("post_reset_sync", obs(0), 23'd0);
    run(na, q.size());
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
